sha_stream_sequencer: RTL
=========================

// Module: sha_stream_sequencer
// PURPOSE
//  Feeds a word stream into the sha256 core, one 512-bit block at a time, and issues its init/next commands.
//  Appends SHA-256 padding in hardware: 0x80000000 word, zero fill, 64-bit bit length.
//  Waits for digest_valid per block and reports done, or error on timeout or length overflow.
//  Sits between the pmu bitstream path and sha256 and replaces the pmu's ad-hoc sha_* driving.
// PARAMETERS
//  CNT_W    27     message word counter width; max message 2^CNT_W-1 words
//  TIMEOUT  1023   cycles to wait for digest_valid after a command before error
// PORTS
//  clk             in   1   clock, shared with sha256
//  reset_n         in   1   asynchronous active-low reset
//  start           in   1   pulse: begin new message; ignored unless busy=0
//  word_i          in   32  message word, big-endian per SHA-256
//  word_valid_i    in   1   word_i valid
//  word_last_i     in   1   word_i is final message word (qualified by valid)
//  word_ready_o    out  1   sequencer accepts word_i this cycle
//  sha_reset_n_w   out  1   sha256 reset_n
//  sha_cs_w        out  1   sha256 chip select
//  sha_we_w        out  1   data write: shifts sha_write_data_w into core block register
//  sha_wc_w        out  1   command write: write_data[0]=init, [1]=next
//  sha_address_w   out  3   data: slot[2:0]; command: 3'd0
//  sha_write_data_w out 32  data word or command word
//  sha_digest_valid_w in 1  sha256 digest ready
//  busy_o          out  1   message in progress
//  done_o          out  1   one-cycle pulse: final digest valid
//  error_o         out  1   sticky until next start: timeout or overflow
// BEHAVIOUR
//  Reset: all outputs 0 except sha_reset_n_w=1. State=IDLE, counters 0.
//  All sha_* outputs registered. An accepted word appears with cs=we=1 on the next cycle.
//  Handshake: transfer when word_valid_i & word_ready_o. word_ready_o=1 only in ACCEPT.
//  Per-block slot counter 0..15. Message word counter n. Bit length L = n*32, 64 bits, zero-extended.
//  FSM:
//   IDLE: start -> CLR; busy_o=1; error_o cleared; n=0; first=1.
//   CLR: sha_reset_n_w=0 for exactly 1 cycle -> ACCEPT.
//   ACCEPT: each transfer writes slot, slot++, n++.
//     Slot 15 written -> CMD, then return to ACCEPT.
//     If that word had last=1 -> CMD then PAD80 (0x80 goes to slot 0 of a new block).
//     last=1 at slot<15 -> PAD80.
//   PAD80: write 0x80000000 -> ZERO.
//   ZERO: write 0 while slot<14. Slot 14 reached -> LENHI.
//     Exception: if 0x80 landed in slot 14 or 15, zero-fill to 15 -> CMD -> ZERO on a fresh block.
//   LENHI: write L[63:32]. LENLO: write L[31:0] at slot 15 -> CMD (final=1).
//   CMD: 1 cycle, cs=wc=1, data={30'b0, ~first, first}; first<=0; slot<=0 -> WAIT.
//   WAIT: ignore digest_valid for 2 cycles after CMD, then wait for it high.
//     High -> next state (ACCEPT, ZERO or PAD80 as queued; if final: DONE).
//     Timer reaching TIMEOUT -> ERR.
//   DONE: done_o=1 one cycle, busy_o=0 -> IDLE.
//   ERR: error_o=1, busy_o=0 -> IDLE.
//  Overflow: a transfer when n == all-ones -> ERR. That word is not written.
//  start while busy: ignored. word_valid_i outside ACCEPT: not accepted.
//  Zero-length messages are not supported: the first accepted word is message data.
//  Asynchronous reset mid-message: immediate return to reset state; core state is discarded.
// TESTING
//  1 word 0x00000000, last -> slots: 0, 0x80000000, 12x0, 0, 0x20; one CMD data=1; done_o after digest_valid.
//  14 words (last on 14th) -> block 1: 14 words, 0x80000000, 0, CMD=1.
//    Block 2: 14x0, 0, 0x1C0, CMD=2. Exactly 2 done-path commands, done_o once.
//  16 words -> CMD=1 after word 16. Block 2: 0x80000000, 13x0, 0, 0x200, CMD=2.
//  digest_valid held 0 -> error_o=1 at TIMEOUT+1 cycles after CMD; busy_o=0; next start clears error_o.
//  Deassert word_valid_i randomly and hold digest_valid=1 across CMD
//    -> no dropped or duplicated words; WAIT honours the 2-cycle ignore window.
//  reset_n low mid-ACCEPT -> all outputs at reset values same cycle; new start reprocesses cleanly.

Source files
------------

// File: rtl/sha_stream_sequencer.sv
// Streams message words into a sha256 core one 512-bit block at a time, appends
// SHA-256 padding (0x80000000, zero fill, 64-bit bit length) and issues init/next.
module sha_stream_sequencer #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  input  logic        word_last_i,
  output logic        word_ready_o,
  output logic        sha_reset_n_w,
  output logic        sha_cs_w,
  output logic        sha_we_w,
  output logic        sha_wc_w,
  output logic [2:0]  sha_address_w,
  output logic [31:0] sha_write_data_w,
  input  logic        sha_digest_valid_w,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [TW-1:0] IGNORE_V  = TW'(3);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_ACCEPT, S_PAD80, S_ZERO, S_LENHI, S_LENLO,
    S_CMD, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_state_nxt;
  state_t           r_ret, w_ret_nxt;
  logic [3:0]       r_slot, w_slot_nxt;
  logic [CNT_W-1:0] r_n, w_n_nxt;
  logic             r_first, w_first_nxt;
  logic             r_final, w_final_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_error, w_error_nxt;
  logic             r_sha_rstn, w_sha_rstn_nxt;
  logic             r_sha_cs, w_sha_cs_nxt;
  logic             r_sha_we, w_sha_we_nxt;
  logic             r_sha_wc, w_sha_wc_nxt;
  logic [2:0]       r_sha_addr, w_sha_addr_nxt;
  logic [31:0]      r_sha_data, w_sha_data_nxt;
  logic             w_wr;
  logic [31:0]      w_wr_data;
  logic [63:0]      w_len;

  assign w_len = 64'(r_n) << 5;

  // Handshake: a word transfers on a cycle where word_valid_i & word_ready_o;
  // ready depends only on state (ACCEPT), never on valid.
  assign word_ready_o     = (r_state == S_ACCEPT);
  assign busy_o           = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign done_o           = (r_state == S_DONE);
  assign error_o          = r_error;
  assign sha_reset_n_w    = r_sha_rstn;
  assign sha_cs_w         = r_sha_cs;
  assign sha_we_w         = r_sha_we;
  assign sha_wc_w         = r_sha_wc;
  assign sha_address_w    = r_sha_addr;
  assign sha_write_data_w = r_sha_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ret      <= S_ACCEPT;
      r_slot     <= '0;
      r_n        <= '0;
      r_first    <= 1'b0;
      r_final    <= 1'b0;
      r_timer    <= '0;
      r_error    <= 1'b0;
      r_sha_rstn <= 1'b1;
      r_sha_cs   <= 1'b0;
      r_sha_we   <= 1'b0;
      r_sha_wc   <= 1'b0;
      r_sha_addr <= '0;
      r_sha_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret      <= w_ret_nxt;
      r_slot     <= w_slot_nxt;
      r_n        <= w_n_nxt;
      r_first    <= w_first_nxt;
      r_final    <= w_final_nxt;
      r_timer    <= w_timer_nxt;
      r_error    <= w_error_nxt;
      r_sha_rstn <= w_sha_rstn_nxt;
      r_sha_cs   <= w_sha_cs_nxt;
      r_sha_we   <= w_sha_we_nxt;
      r_sha_wc   <= w_sha_wc_nxt;
      r_sha_addr <= w_sha_addr_nxt;
      r_sha_data <= w_sha_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret;
    w_slot_nxt     = r_slot;
    w_n_nxt        = r_n;
    w_first_nxt    = r_first;
    w_final_nxt    = r_final;
    w_timer_nxt    = r_timer;
    w_error_nxt    = r_error;
    w_sha_rstn_nxt = 1'b1;
    w_sha_cs_nxt   = 1'b0;
    w_sha_we_nxt   = 1'b0;
    w_sha_wc_nxt   = 1'b0;
    w_sha_addr_nxt = '0;
    w_sha_data_nxt = '0;
    w_wr           = 1'b0;
    w_wr_data      = '0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_CLR;
        w_error_nxt = 1'b0;
        w_n_nxt     = '0;
        w_slot_nxt  = '0;
        w_first_nxt = 1'b1;
        w_final_nxt = 1'b0;
      end
      S_CLR: begin
        w_sha_rstn_nxt = 1'b0;
        w_state_nxt    = S_ACCEPT;
      end
      S_ACCEPT: if (word_valid_i) begin
        if (r_n == '1) begin
          w_state_nxt = S_ERR;
          w_error_nxt = 1'b1;
        end else begin
          w_wr       = 1'b1;
          w_wr_data  = word_i;
          w_n_nxt    = r_n + CNT_W'(1);
          w_slot_nxt = r_slot + 4'd1;
          if (r_slot == 4'd15) begin
            w_state_nxt = S_CMD;
            w_ret_nxt   = word_last_i ? S_PAD80 : S_ACCEPT;
          end else if (word_last_i) begin
            w_state_nxt = S_PAD80;
          end
        end
      end
      S_PAD80, S_ZERO: begin
        // Slot 15 is only reached here when 0x80 landed in slot 14/15: close the
        // block and zero-fill a fresh one before the length words.
        w_wr       = 1'b1;
        w_wr_data  = (r_state == S_PAD80) ? 32'h8000_0000 : 32'h0;
        w_slot_nxt = r_slot + 4'd1;
        if (r_slot == 4'd15) begin
          w_state_nxt = S_CMD;
          w_ret_nxt   = S_ZERO;
        end else if (r_slot == 4'd13) begin
          w_state_nxt = S_LENHI;
        end else begin
          w_state_nxt = S_ZERO;
        end
      end
      S_LENHI: begin
        w_wr        = 1'b1;
        w_wr_data   = w_len[63:32];
        w_slot_nxt  = r_slot + 4'd1;
        w_state_nxt = S_LENLO;
      end
      S_LENLO: begin
        w_wr        = 1'b1;
        w_wr_data   = w_len[31:0];
        w_final_nxt = 1'b1;
        w_state_nxt = S_CMD;
      end
      S_CMD: begin
        w_sha_cs_nxt   = 1'b1;
        w_sha_wc_nxt   = 1'b1;
        w_sha_data_nxt = {30'b0, ~r_first, r_first};
        w_first_nxt    = 1'b0;
        w_slot_nxt     = '0;
        w_timer_nxt    = TW'(1);
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // r_timer counts cycles since CMD; digest_valid is stale during the first two.
        if (r_timer >= IGNORE_V && sha_digest_valid_w) begin
          w_state_nxt = r_final ? S_DONE : r_ret;
        end else if (r_timer == TIMEOUT_V) begin
          w_state_nxt = S_ERR;
          w_error_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_wr) begin
      w_sha_cs_nxt   = 1'b1;
      w_sha_we_nxt   = 1'b1;
      w_sha_addr_nxt = r_slot[2:0];
      w_sha_data_nxt = w_wr_data;
    end
  end

endmodule
